mmu_ptw: RTL

//  Sv32 hardware page-table walker and TLB refill sequencer. Accepts a miss from the
//  MMU lookup stage, walks the two-level table over a single-outstanding memory port,

---
 rtl/mmu_pkg.sv | 33 +++
 rtl/ptw_pte_check.sv | 35 +++
 rtl/mmu_ptw.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared Sv32 MMU types: walker state encoding, PTE layout and page-geometry constants.
// The PTE check honours the optional PTW_AD_FAULT_EN (Svade) build macro.
package mmu_pkg;

   localparam int PAGE_OFS_W = 12;
   localparam int LVL_W      = 10;

   typedef enum logic [2:0] {
      PTW_IDLE    = 3'd0,
      PTW_L1_REQ  = 3'd1,
      PTW_L1_WAIT = 3'd2,
      PTW_L0_REQ  = 3'd3,
      PTW_L0_WAIT = 3'd4,
      PTW_REFILL  = 3'd5,
      PTW_FAULT   = 3'd6,
      PTW_RESP    = 3'd7
   } ptw_state_e;

   typedef struct packed {
      logic [11:0] ppn1;
      logic [9:0]  ppn0;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } sv32_pte_t;

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational Sv32 PTE decode: leaf / next-level pointer / page fault for one walk level.
// Define PTW_AD_FAULT_EN to fault on leaves with A=0, or D=0 on a store (Svade).
module ptw_pte_check
   import mmu_pkg::*;
(
   input  sv32_pte_t pte_i,
   input  logic      level_i,
   input  logic      store_i,
   output logic      leaf_o,
   output logic      ptr_o,
   output logic      pf_o
);

   logic invalid;
   logic misaligned;
   logic ad_fault;
   logic unused_bits;

   assign invalid    = ~pte_i.v | (~pte_i.r & pte_i.w);
   assign leaf_o     = pte_i.r | pte_i.x;
   // a megapage leaf must have a zero low PPN field
   assign misaligned = leaf_o & level_i & (pte_i.ppn0 != '0);

`ifdef PTW_AD_FAULT_EN
   assign ad_fault    = leaf_o & (~pte_i.a | (store_i & ~pte_i.d));
   assign unused_bits = ^{pte_i.ppn1, pte_i.rsw, pte_i.g, pte_i.u};
`else
   assign ad_fault    = 1'b0;
   assign unused_bits = ^{pte_i.ppn1, pte_i.rsw, pte_i.g, pte_i.u, pte_i.a, pte_i.d, store_i};
`endif

   assign ptr_o = ~invalid & ~leaf_o & level_i;
   assign pf_o  = invalid | misaligned | ad_fault | (~leaf_o & ~level_i);

endmodule

// File: rtl/mmu_ptw.sv
// Sv32 two-level page-table walker with TLB refill over a single-outstanding memory port.
// Leaf checks live in ptw_pte_check; PTW_AD_FAULT_EN enables Svade A/D faults there.
module mmu_ptw
   import mmu_pkg::*;
#(
   parameter int PA_W  = 34,
   parameter int VPN_W = 20,
   parameter int PTE_W = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [VPN_W-1:0] req_vpn,
   input  logic             req_store,
   input  logic [21:0]      satp_ppn,
   output logic             resp_valid,
   output logic             resp_pf,
   output logic             resp_af,
   output logic             resp_abort,
   output logic             mem_req,
   output logic [PA_W-1:0]  mem_addr,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_err,
   output logic             tlb_cs,
   output logic             tlb_we,
   output logic [VPN_W-1:0] tlb_vpn,
   output logic             tlb_spage,
   output logic [PTE_W-1:0] tlb_pte,
   input  logic             flush_req
);

   ptw_state_e       state_q, state_d;
   logic [VPN_W-1:0] vpn_q, vpn_d;
   logic             store_q, store_d;
   logic [PA_W-1:0]  addr_q, addr_d;
   logic [31:0]      pte_q, pte_d;
   logic             spage_q, spage_d;
   logic             pf_q, pf_d;
   logic             af_q, af_d;
   logic             abort_q, abort_d;
   logic             chk_leaf, chk_ptr, chk_pf;
   logic             refill_we;

   ptw_pte_check u_pte_check (
      .pte_i   (sv32_pte_t'(mem_rdata)),
      .level_i (state_q == PTW_L1_WAIT),
      .store_i (store_q),
      .leaf_o  (chk_leaf),
      .ptr_o   (chk_ptr),
      .pf_o    (chk_pf)
   );

   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      store_d = store_q;
      addr_d  = addr_q;
      pte_d   = pte_q;
      spage_d = spage_q;
      pf_d    = pf_q;
      af_d    = af_q;
      abort_d = abort_q;
      case (state_q)
         PTW_IDLE: begin
            if (req_valid) begin
               vpn_d   = req_vpn;
               store_d = req_store;
               addr_d  = {satp_ppn, req_vpn[2*LVL_W-1:LVL_W], 2'b00};
               spage_d = 1'b0;
               pf_d    = 1'b0;
               af_d    = 1'b0;
               abort_d = 1'b0;
               state_d = PTW_L1_REQ;
            end
         end
         PTW_L1_REQ, PTW_L0_REQ: begin
            // a grant in the flush cycle still owes us a beat, so wait for it
            if (mem_gnt) begin
               abort_d = flush_req;
               if (state_q == PTW_L1_REQ) state_d = PTW_L1_WAIT;
               else                       state_d = PTW_L0_WAIT;
            end else if (flush_req) begin
               abort_d = 1'b1;
               state_d = PTW_RESP;
            end
         end
         PTW_L1_WAIT, PTW_L0_WAIT: begin
            if (flush_req) abort_d = 1'b1;
            if (mem_rvalid) begin
               pte_d = mem_rdata;
               if (abort_q || flush_req) begin
                  state_d = PTW_RESP;
               end else if (mem_err) begin
                  af_d    = 1'b1;
                  state_d = PTW_FAULT;
               end else if (chk_pf) begin
                  pf_d    = 1'b1;
                  state_d = PTW_FAULT;
               end else if (chk_ptr) begin
                  addr_d  = {mem_rdata[31:LVL_W], vpn_q[LVL_W-1:0], 2'b00};
                  state_d = PTW_L0_REQ;
               end else if (chk_leaf) begin
                  spage_d = (state_q == PTW_L1_WAIT);
                  state_d = PTW_REFILL;
               end else begin
                  pf_d    = 1'b1;
                  state_d = PTW_FAULT;
               end
            end
         end
         PTW_REFILL, PTW_FAULT: begin
            if (flush_req) abort_d = 1'b1;
            state_d = PTW_RESP;
         end
         PTW_RESP: state_d = PTW_IDLE;
         default:  state_d = PTW_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= PTW_IDLE;
         vpn_q   <= '0;
         store_q <= 1'b0;
         addr_q  <= '0;
         pte_q   <= '0;
         spage_q <= 1'b0;
         pf_q    <= 1'b0;
         af_q    <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         store_q <= store_d;
         addr_q  <= addr_d;
         pte_q   <= pte_d;
         spage_q <= spage_d;
         pf_q    <= pf_d;
         af_q    <= af_d;
         abort_q <= abort_d;
      end
   end

   // flush in the refill cycle must keep the stale translation out of the TLB
   assign refill_we  = (state_q == PTW_REFILL) & ~flush_req & ~abort_q;

   assign req_ready  = (state_q == PTW_IDLE);
   assign mem_req    = (state_q == PTW_L1_REQ) | (state_q == PTW_L0_REQ);
   assign mem_addr   = addr_q;

   assign tlb_cs     = refill_we;
   assign tlb_we     = refill_we;
   assign tlb_vpn    = refill_we ? vpn_q : '0;
   assign tlb_spage  = refill_we & spage_q;
   assign tlb_pte    = refill_we ? {{(PTE_W-32){1'b0}}, pte_q} : '0;

   assign resp_valid = (state_q == PTW_RESP);
   assign resp_abort = resp_valid & abort_q;
   assign resp_pf    = resp_valid & pf_q & ~abort_q;
   assign resp_af    = resp_valid & af_q & ~abort_q;

endmodule
